hazard_stall_ctrl: RTL

Pipeline sequencing controller for the ID stage of the 5-stage MIPS datapath.
- Detects load-use hazards and holds PC and IF/ID when one is found.
- Inserts ID/EX bubbles while a multi-cycle MUL occupies the multiplier.
- Flushes IF/ID on a taken branch resolved in EX.
- Drives the zero/sign mode select of the immediate extension unit from the instruction in ID.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/mips_ctrl_pkg.sv | 32 +++
 rtl/load_use_detect.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: opcodes, funct codes and ID-stage controller states.
// Pure declarations; no latency or backpressure of its own.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FUNCT_MUL   = 6'h02;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } ctrl_state_t;

    // Opcodes whose rt field is read rather than written.
    function automatic logic rt_is_src(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_SPECIAL2, OP_BEQ, OP_BNE,
            OP_SB, OP_SH, OP_SW: rt_is_src = 1'b1;
            default:             rt_is_src = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect between the instruction in ID and a load in EX.
// Purely combinational, zero latency; no backpressure of its own.
module load_use_detect
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    output logic        lu
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_low;

    assign op = instr[31:26];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign unused_low = ^instr[15:0];

    // $zero never carries a real dependency.
    assign lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                ((id_ex_rt == rs) || (rt_is_src(op) && (id_ex_rt == rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage sequencing: load-use stall, MUL_WAIT bubbles, branch flush, imm-extend mode, stall counter.
// Control outputs are combinational from registered state plus same-cycle inputs (0 cycles).
// Stalls hold PC and IF/ID and bubble ID/EX; a taken branch overrides the hold and flushes IF/ID.
module hazard_stall_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] if_id_instr,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ext_zero,
    output logic        mul_busy,
    output logic [15:0] stall_count
);

    localparam logic [3:0] CNT_INIT  = 4'(MUL_LATENCY - 1);
    localparam logic       MUL_MULTI = (MUL_LATENCY > 1);

    ctrl_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        is_mul;
    logic        lu;
    logic        stall;

    assign op     = if_id_instr[31:26];
    assign funct  = if_id_instr[5:0];
    assign is_mul = (op == OP_SPECIAL2) && (funct == FUNCT_MUL);

    load_use_detect u_lu (
        .instr          (if_id_instr),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .lu             (lu)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (is_mul && !lu && !ex_branch_taken && MUL_MULTI) begin
                    state_nxt = ST_MUL_WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            ST_MUL_WAIT: begin
                // A branch here should be impossible; if seen, freeze the wait.
                if (!ex_branch_taken) begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign stall = (state == ST_MUL_WAIT) || (lu && (state == ST_RUN));

    // Reset holds the front end and feeds NOPs into EX.
    assign pc_write     = reset_n && (!stall || ex_branch_taken);
    assign if_id_write  = pc_write;
    assign if_id_flush  = reset_n && ex_branch_taken;
    assign id_ex_bubble = !reset_n || stall || ex_branch_taken;
    assign mul_busy     = (state == ST_MUL_WAIT);
    assign ext_zero     = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= 16'd0;
        end else if (stall && !ex_branch_taken && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
